// File: rtl/branch_update.sv
// branch_update: buffers resolved branch outcomes and drains one predictor
// table write per cycle; flags mispredictions with a corrected GHR.
//
// Ports:
//   clk_in, rst_in (async, active-low)
//   resolve_*          : resolved-branch input handshake and payload
//   upd_*              : predictor table write port driven from the queue head
//   mispredict_out     : one-cycle pulse the cycle after a mispredicted accept
//   ghr_restore_out    : corrected GHR, valid with mispredict_out, held otherwise
//   branch_count_out   : accepted branches (wraps at 2^32)
//   mispredict_count_out : accepted mispredicted branches (wraps at 2^32)
module branch_update #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned LHT_DEPTH    = 8,
  parameter int unsigned GLOBAL_DEPTH = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    resolve_valid_in,
  output logic                    resolve_ready_out,
  input  logic [31:0]             resolve_pc_in,
  input  logic                    resolve_taken_in,
  input  logic                    resolve_pred_taken_in,
  input  logic                    resolve_local_pred_in,
  input  logic                    resolve_global_pred_in,
  input  logic [GLOBAL_DEPTH-1:0] resolve_ghr_in,
  output logic                    upd_valid_out,
  input  logic                    upd_ready_in,
  output logic [LHT_DEPTH-1:0]    upd_lht_idx_out,
  output logic [GLOBAL_DEPTH-1:0] upd_global_idx_out,
  output logic                    upd_taken_out,
  output logic                    upd_choice_we_out,
  output logic                    upd_choice_global_out,
  output logic                    mispredict_out,
  output logic [GLOBAL_DEPTH-1:0] ghr_restore_out,
  output logic [31:0]             branch_count_out,
  output logic [31:0]             mispredict_count_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [LHT_DEPTH-1:0]    lht_idx;
    logic [GLOBAL_DEPTH-1:0] global_idx;
    logic                    taken;
    logic                    choice_we;
    logic                    choice_global;
  } entry_t;

  entry_t                  mem_q [DEPTH];
  entry_t                  mem_d [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    ready_q, ready_d;
  logic                    valid_q, valid_d;
  logic                    mispredict_q, mispredict_d;
  logic [GLOBAL_DEPTH-1:0] ghr_restore_q, ghr_restore_d;
  logic [31:0]             branch_count_q, branch_count_d;
  logic [31:0]             mispredict_count_q, mispredict_count_d;

  logic   push_c;
  logic   pop_c;
  logic   mispredict_c;
  entry_t new_entry_c;
  entry_t head_c;

  // Only a slice of the PC feeds the indices; fold the rest away.
  logic unused_pc;
  assign unused_pc = ^resolve_pc_in;

  assign push_c       = resolve_valid_in && ready_q;
  assign pop_c        = valid_q && upd_ready_in;
  assign mispredict_c = push_c && (resolve_taken_in != resolve_pred_taken_in);

  // Per-entry table write fields, computed once at accept.
  always_comb begin
    new_entry_c               = '0;
    new_entry_c.lht_idx       = resolve_pc_in[LHT_DEPTH+1:2];
    new_entry_c.global_idx    = resolve_ghr_in ^ resolve_pc_in[GLOBAL_DEPTH+1:2];
    new_entry_c.taken         = resolve_taken_in;
    new_entry_c.choice_we     = resolve_local_pred_in != resolve_global_pred_in;
    new_entry_c.choice_global = resolve_global_pred_in == resolve_taken_in;
  end

  // Queue bookkeeping, mispredict response and counters.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) mem_d[i] = mem_q[i];
    wr_ptr_d           = wr_ptr_q;
    rd_ptr_d           = rd_ptr_q;
    count_d            = count_q;
    ghr_restore_d      = ghr_restore_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    mispredict_d       = mispredict_c;

    if (push_c) begin
      mem_d[wr_ptr_q] = new_entry_c;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      branch_count_d  = branch_count_q + 32'd1;
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
    else if (!push_c && pop_c) count_d = count_q - CNT_W'(1);

    if (mispredict_c) begin
      ghr_restore_d      = {resolve_ghr_in[GLOBAL_DEPTH-2:0], resolve_taken_in};
      mispredict_count_d = mispredict_count_q + 32'd1;
    end

    ready_d = count_d < CNT_W'(DEPTH);
    valid_d = count_d != '0;
  end

  // State registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q           <= '0;
      rd_ptr_q           <= '0;
      count_q            <= '0;
      ready_q            <= 1'b1;
      valid_q            <= 1'b0;
      mispredict_q       <= 1'b0;
      ghr_restore_q      <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
      wr_ptr_q           <= wr_ptr_d;
      rd_ptr_q           <= rd_ptr_d;
      count_q            <= count_d;
      ready_q            <= ready_d;
      valid_q            <= valid_d;
      mispredict_q       <= mispredict_d;
      ghr_restore_q      <= ghr_restore_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign head_c                = mem_q[rd_ptr_q];
  assign resolve_ready_out     = ready_q;
  assign upd_valid_out         = valid_q;
  assign upd_lht_idx_out       = head_c.lht_idx;
  assign upd_global_idx_out    = head_c.global_idx;
  assign upd_taken_out         = head_c.taken;
  assign upd_choice_we_out     = head_c.choice_we;
  assign upd_choice_global_out = head_c.choice_global;
  assign mispredict_out        = mispredict_q;
  assign ghr_restore_out       = ghr_restore_q;
  assign branch_count_out      = branch_count_q;
  assign mispredict_count_out  = mispredict_count_q;

endmodule

// File: doc/branch_update.md
# branch_update

Resolution-side companion to `branch_predict` in the superscalar core. It accepts resolved branch outcomes from the execute/commit stage and buffers them in a small FIFO. It drains one predictor-table write per cycle toward the predictor's local, global and choice tables, and flags mispredictions with a global-history restore value for the fetch front end.

## Interface

Parameters:
- `DEPTH`, 4: outcome queue entries; power of two, ≥2.
- `LHT_DEPTH`, 8: local history table index width.
- `GLOBAL_DEPTH`, 8: global history register width and global/choice index width.

Ports:
- `clk_in`  in  1  single clock, rising edge.
- `rst_in`  in  1  asynchronous, active-low reset.
- `resolve_valid_in`  in  1  resolved branch presented.
- `resolve_ready_out`  out  1  queue can accept (`count < DEPTH`).
- `resolve_pc_in`  in  32  branch PC.
- `resolve_taken_in`  in  1  actual outcome.
- `resolve_pred_taken_in`  in  1  final prediction used at fetch.
- `resolve_local_pred_in`  in  1  local component prediction at fetch.
- `resolve_global_pred_in`  in  1  global component prediction at fetch.
- `resolve_ghr_in`  in  GLOBAL_DEPTH  GHR snapshot at prediction time.
- `upd_valid_out`  out  1  table write pending (queue non-empty).
- `upd_ready_in`  in  1  predictor accepts write this cycle.
- `upd_lht_idx_out`  out  LHT_DEPTH  `pc[LHT_DEPTH+1:2]`.
- `upd_global_idx_out`  out  GLOBAL_DEPTH  `ghr ^ pc[GLOBAL_DEPTH+1:2]`.
- `upd_taken_out`  out  1  outcome to train both counters.
- `upd_choice_we_out`  out  1  choice counter write enable.
- `upd_choice_global_out`  out  1  1 = move choice toward global, 0 = toward local.
- `mispredict_out`  out  1  one-cycle pulse per mispredicted branch.
- `ghr_restore_out`  out  GLOBAL_DEPTH  corrected GHR, valid with `mispredict_out`.
- `branch_count_out`  out  32  accepted branches.
- `mispredict_count_out`  out  32  accepted mispredicted branches.

## Operation

- Accept when `resolve_valid_in && resolve_ready_out`. Inputs are ignored when ready is low.
- Indices and choice fields are computed at accept and stored per entry. The entry holds the LHT index, global index, taken, choice write enable and choice direction.
- `choice_we = local_pred != global_pred`.
- `choice_global = (global_pred == taken)`.
- Queue: circular buffer with read/write pointers of `$clog2(DEPTH)` bits. Pointers wrap modulo DEPTH. The occupancy counter is `$clog2(DEPTH)+1` bits.
- `upd_*` outputs are driven from the head entry.
- Pop when `upd_valid_out && upd_ready_in`.
- Full: `resolve_ready_out=0`. There is no push-through when full, even if a pop occurs the same cycle.
- Simultaneous push and pop when not full: occupancy unchanged, both pointers advance.
- Empty: `upd_valid_out=0`. The head fields hold their last value, and their contents are don't-care.
- Mispredict: an accepted entry with `taken != pred_taken` is a mispredict.
  - Registered response: `mispredict_out=1` for exactly one cycle, the cycle after accept.
  - `ghr_restore_out = {ghr[GLOBAL_DEPTH-2:0], taken}` in that same cycle.
  - This path is independent of queue occupancy and drain.
  - `ghr_restore_out` holds its value when `mispredict_out` is low.
- Counters: `branch_count_out` increments on every accept. `mispredict_count_out` increments on every mispredicted accept. Both update at the same edge as the `mispredict_out` register and wrap at 2^32.

## Timing

- Reset (`rst_in` low, asynchronous) takes effect immediately:
  - pointers and occupancy = 0;
  - `upd_valid_out=0`, `mispredict_out=0`, `ghr_restore_out=0`, both counters 0;
  - `resolve_ready_out=1`; all `upd_*` data outputs 0.
- Reset asserted mid-drain discards all queued entries. No write is issued in the reset cycle.
- Accept-to-update latency: an entry pushed at edge N into an empty queue gives `upd_valid_out=1` after edge N.
- Throughput: one accept and one drain per cycle.
- `upd_*` outputs must stay stable while `upd_valid_out && !upd_ready_in` (backpressure).
- `mispredict_out` latency is exactly 1 cycle from accept, even when the queue is full of older entries.

## Test plan

- **Reset values:** release reset → all outputs at reset values, `resolve_ready_out=1`. Assert reset with 3 queued entries → `upd_valid_out` drops immediately, and the counters read 0.
- **Correct prediction:** accept `pc=0x0000_0104`, taken=1, pred=1, local=1, global=0, ghr=0x5A, with defaults. Next cycle expect:
  - `upd_lht_idx_out=0x41`, `upd_global_idx_out=0x1B`, `upd_taken_out=1`;
  - `upd_choice_we_out=1`, `upd_choice_global_out=0`;
  - `mispredict_out=0`, `branch_count_out=1`.
- **Mispredict:** accept taken=0, pred=1, ghr=0x81 → next cycle `mispredict_out=1`, `ghr_restore_out=0x02`, `mispredict_count_out=1`. The following cycle `mispredict_out=0`.
- **Full and backpressure:** hold `upd_ready_in=0` and push 4 entries → `resolve_ready_out=0`, and a 5th valid is not counted. Then assert `upd_ready_in=1` with valid asserted continuously → exactly one drain per cycle, FIFO order preserved, no accept while the queue is full.
- **Wrap-around:** continuous push/pop with `upd_ready_in=1` for 10 entries of distinct PCs → all 10 entries emerge in order across pointer wrap, and `branch_count_out=10`.
- **Agreement case:** local=global=1, taken=0 → `upd_choice_we_out=0`, and `mispredict_out` is set only if pred=1.
